// File: rtl/dma_pkg.sv
// Shared DMA types: scheduler FSM states and engine transfer modes.
// Pure declarations, no logic, latency or flow control.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        MEM2MEM = 2'd0,
        MEM2IO  = 2'd1,
        IO2MEM  = 2'd2
    } xfer_mode_t;

endpackage

// File: rtl/dma_rr_scheduler_if.sv
// Channel/engine <-> scheduler signal bundle; master = scheduler, slave = channels/engine.
// The prio vector exists only when DMA_SCHED_PRIO_EN is defined.
interface dma_rr_scheduler_if #(
    parameter int CHANNEL_COUNT    = 4,
    parameter int MAX_BURST_LENGTH = 16
);
    localparam int CH_IDX_W = $clog2(CHANNEL_COUNT);
    localparam int CNT_W    = $clog2(MAX_BURST_LENGTH + 1);

    logic [CHANNEL_COUNT-1:0] req;
    logic [CHANNEL_COUNT-1:0] last;
    logic                     beat_done;
`ifdef DMA_SCHED_PRIO_EN
    logic [CHANNEL_COUNT-1:0] prio;
`endif
    logic [CHANNEL_COUNT-1:0] grant;
    logic                     grant_valid;
    logic [CH_IDX_W-1:0]      grant_id;
    logic [CNT_W-1:0]         burst_cnt;
    logic                     spurious_beat;

`ifdef DMA_SCHED_PRIO_EN
    modport master (
        input  req, last, beat_done, prio,
        output grant, grant_valid, grant_id, burst_cnt, spurious_beat
    );
    modport slave (
        output req, last, beat_done, prio,
        input  grant, grant_valid, grant_id, burst_cnt, spurious_beat
    );
`else
    modport master (
        input  req, last, beat_done,
        output grant, grant_valid, grant_id, burst_cnt, spurious_beat
    );
    modport slave (
        output req, last, beat_done,
        input  grant, grant_valid, grant_id, burst_cnt, spurious_beat
    );
`endif

endinterface

// File: rtl/dma_rr_pick.sv
// Rotate-from-pointer priority picker: first set req at index >= ptr, wrapping.
// Purely combinational (0 cycles); no flow control.
module dma_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single conditional subtract wraps the sum
            pos = {1'b0, ptr} + (W+1)'(k);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (!any && req[pos[W-1:0]]) begin
                any                 = 1'b1;
                onehot[pos[W-1:0]] = 1'b1;
                idx                 = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_rr_scheduler.sv
// Round-robin DMA engine scheduler; grant 1 cycle after req, 2 dead cycles between grants.
// Backpressure: grant held until last beat, MAX_BURST_LENGTH beats, or req drop; DMA_SCHED_PRIO_EN adds a prio class.
module dma_rr_scheduler
    import dma_pkg::*;
#(
    parameter int CHANNEL_COUNT    = 4,
    parameter int MAX_BURST_LENGTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dma_rr_scheduler_if.master  bus
);

    localparam int CH_IDX_W = $clog2(CHANNEL_COUNT);
    localparam int CNT_W    = $clog2(MAX_BURST_LENGTH + 1);

    sched_state_t               state_q, state_d;
    logic [CHANNEL_COUNT-1:0]   grant_q, grant_d;
    logic                       grant_valid_q, grant_valid_d;
    logic [CH_IDX_W-1:0]        grant_id_q, grant_id_d;
    logic [CH_IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           burst_cnt_q, burst_cnt_d;
    logic                       spurious_q, spurious_d;
    logic                       release_now;

    logic [CHANNEL_COUNT-1:0]   all_oh, pick_oh;
    logic [CH_IDX_W-1:0]        all_idx, pick_idx;
    logic                       all_any, pick_any;

    dma_rr_pick #(.N(CHANNEL_COUNT), .W(CH_IDX_W)) u_pick_all (
        .req    (bus.req),
        .ptr    (rr_ptr_q),
        .onehot (all_oh),
        .idx    (all_idx),
        .any    (all_any)
    );

`ifdef DMA_SCHED_PRIO_EN
    logic [CHANNEL_COUNT-1:0]   hi_oh;
    logic [CH_IDX_W-1:0]        hi_idx;
    logic                       hi_any;

    // Both classes share rr_ptr so fairness within each class follows the last grant
    dma_rr_pick #(.N(CHANNEL_COUNT), .W(CH_IDX_W)) u_pick_hi (
        .req    (bus.req & bus.prio),
        .ptr    (rr_ptr_q),
        .onehot (hi_oh),
        .idx    (hi_idx),
        .any    (hi_any)
    );

    assign pick_oh  = hi_any ? hi_oh  : all_oh;
    assign pick_idx = hi_any ? hi_idx : all_idx;
    assign pick_any = all_any;
`else
    assign pick_oh  = all_oh;
    assign pick_idx = all_idx;
    assign pick_any = all_any;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        spurious_d    = bus.beat_done && !grant_valid_q;
        release_now   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d       = GRANT;
                    grant_d       = pick_oh;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    burst_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (bus.beat_done) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    release_now = bus.last[grant_id_q] || !bus.req[grant_id_q] ||
                                  (burst_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST_LENGTH));
                end else begin
                    release_now = !bus.req[grant_id_q];
                end
                if (release_now) begin
                    state_d       = HANDOFF;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    rr_ptr_d      = (grant_id_q == CH_IDX_W'(CHANNEL_COUNT - 1)) ?
                                    '0 : grant_id_q + CH_IDX_W'(1);
                end
            end
            HANDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            spurious_q    <= spurious_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = grant_valid_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.burst_cnt     = burst_cnt_q;
    assign bus.spurious_beat = spurious_q;

endmodule
